mux_stream_arb: RTL and testbench

//  N-channel registered stream multiplexer; parametrised successor of the combinational 4:1 mux.

---
 rtl/mux_stream_arb.sv | 92 +++++++++
 tb/tb_mux_stream_arb.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mux_stream_arb.sv
// mux_stream_arb: NUM_CH-way registered valid/ready stream mux, fixed or round-robin select; MUX_STREAM_LAST_EN adds packet lock via in_last/out_last
module mux_stream_arb #(
  parameter int WIDTH    = 8,
  parameter int NUM_CH   = 4,
  parameter int SEL_BITS = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
`ifdef MUX_STREAM_LAST_EN
  input  logic [NUM_CH-1:0]       in_last,
  output logic                    out_last,
`endif
  input  logic                    mode,
  input  logic [SEL_BITS-1:0]     sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_BITS-1:0]     out_ch
);
  logic                load_en;
  logic                xfer;
  logic [NUM_CH-1:0]   grant;
  logic [NUM_CH-1:0]   fix_grant;
  logic [NUM_CH-1:0]   rr_grant;
  logic [SEL_BITS-1:0] gnt_idx;
  logic [SEL_BITS-1:0] rr_ptr;
  assign load_en = !out_valid || out_ready;
  // rr search runs from farthest to nearest so the channel right after rr_ptr wins
  always_comb begin
    fix_grant = '0;
    rr_grant  = '0;
    for (int i = 0; i < NUM_CH; i++)
      fix_grant[i] = in_valid[i] && (sel == SEL_BITS'(i));
    for (int k = NUM_CH; k >= 1; k--) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_CH;
      if (in_valid[idx]) begin
        rr_grant      = '0;
        rr_grant[idx] = 1'b1;
      end
    end
  end
`ifdef MUX_STREAM_LAST_EN
  logic                locked;
  logic [SEL_BITS-1:0] lock_ch;
  logic [NUM_CH-1:0]   lock_grant;
  always_comb begin
    lock_grant = '0;
    for (int i = 0; i < NUM_CH; i++)
      lock_grant[i] = in_valid[i] && (lock_ch == SEL_BITS'(i));
  end
  assign grant = locked ? lock_grant : mode ? rr_grant : fix_grant;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked   <= 1'b0;
      lock_ch  <= '0;
      out_last <= 1'b0;
    end else if (xfer) begin
      locked   <= !in_last[gnt_idx];
      lock_ch  <= gnt_idx;
      out_last <= in_last[gnt_idx];
    end
  end
`else
  assign grant = mode ? rr_grant : fix_grant;
`endif
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_CH; i++)
      gnt_idx = grant[i] ? SEL_BITS'(i) : gnt_idx;
  end
  assign xfer     = load_en && |grant;
  assign in_ready = {NUM_CH{load_en && rst_n}} & grant;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= SEL_BITS'(NUM_CH - 1);
    end else if (load_en) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= in_data[gnt_idx*WIDTH +: WIDTH];
        out_ch   <= gnt_idx;
        if (mode) rr_ptr <= gnt_idx;
      end
    end
  end
endmodule

// File: tb/tb_mux_stream_arb.sv
// tb_mux_stream_arb: directed checks of reset, fixed select, round-robin, backpressure, no-grant and packet lock
module tb_mux_stream_arb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;
  int          errors = 0;
  int          checks = 0;
`ifdef MUX_STREAM_LAST_EN
  logic [3:0]  in_last;
  logic        out_last;
`endif
  always #5 clk = ~clk;
  mux_stream_arb #(.WIDTH(8), .NUM_CH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef MUX_STREAM_LAST_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 4'hF; mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
    in_data = 32'h13121110;
`ifdef MUX_STREAM_LAST_EN
    in_last = 4'hF;
`endif
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_ch got=%0d exp=0", out_ch); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", out_data); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", in_ready); end
`ifdef MUX_STREAM_LAST_EN
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", out_last); end
`endif
    in_valid = 4'h0;
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_fixed();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data = 32'h33A51100; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL fixed_ready got=%b exp=0100", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fixed_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL fixed_data got=%h exp=a5", out_data); end
    checks++; if (out_ch !== 2'd2) begin errors++; $display("FAIL fixed_ch got=%0d exp=2", out_ch); end
    in_valid = 4'b0000;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fixed_drain_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL fixed_hold_data got=%h exp=a5", out_data); end
  endtask
  task automatic test_round_robin();
    logic [1:0] exp_ch [5];
    exp_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    mode = 1'b1; in_valid = 4'hF; in_data = 32'h13121110; out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_ch !== exp_ch[n]) begin
        errors++; $display("FAIL rr_ch[%0d] got=%0d/v%b exp=%0d/v1", n, out_ch, out_valid, exp_ch[n]);
      end
      checks++; if (out_data !== (8'h10 + 8'(exp_ch[n]))) begin
        errors++; $display("FAIL rr_data[%0d] got=%h exp=%h", n, out_data, 8'h10 + 8'(exp_ch[n]));
      end
    end
  endtask
  task automatic test_backpressure();
    out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready got=%b exp=0000", in_ready); end
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h10) begin
        errors++; $display("FAIL bp_hold[%0d] got=v%b ch%0d %h exp=v1 ch0 10", n, out_valid, out_ch, out_data);
      end
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=0000", n, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got=%b exp=0010", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h11) begin
      errors++; $display("FAIL bp_next got=v%b ch%0d %h exp=v1 ch1 11", out_valid, out_ch, out_data);
    end
  endtask
  task automatic test_boundary();
    mode = 1'b0; sel = 2'd1; in_valid = 4'b1101; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bnd_ready got=%b exp=0000", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bnd_valid got=%b exp=0", out_valid); end
    checks++; if (out_ch !== 2'd1 || out_data !== 8'h11) begin
      errors++; $display("FAIL bnd_hold got=ch%0d %h exp=ch1 11", out_ch, out_data);
    end
  endtask
  task automatic test_single_rr();
    mode = 1'b1; in_valid = 4'b1000; out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 8'h13) begin
        errors++; $display("FAIL single[%0d] got=v%b ch%0d %h exp=v1 ch3 13", n, out_valid, out_ch, out_data);
      end
    end
  endtask
`ifdef MUX_STREAM_LAST_EN
  task automatic test_lock();
    logic [1:0] exp_ch [4];
    logic       exp_last [4];
    exp_ch = '{2'd1, 2'd1, 2'd1, 2'd0};
    exp_last = '{1'b0, 1'b0, 1'b1, 1'b0};
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0011; in_last = 4'b0000; out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_ch !== exp_ch[n] || out_last !== exp_last[n]) begin
        errors++; $display("FAIL lock[%0d] got=v%b ch%0d l%b exp=v1 ch%0d l%b", n, out_valid, out_ch, out_last, exp_ch[n], exp_last[n]);
      end
      if (n == 0) begin sel = 2'd0; mode = 1'b1; end
      if (n == 1) begin in_last = 4'b0010; mode = 1'b0; end
    end
  endtask
`endif
  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_boundary();
    test_single_rr();
`ifdef MUX_STREAM_LAST_EN
    test_lock();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
